// File: rtl/dlx_pkg.sv
// Shared DLX fetch definitions: fetch FSM state encoding and word/PC constants.
package dlx_pkg;

    localparam int unsigned WORD_W = 32;
    localparam logic [WORD_W-1:0] PC_INC = 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_LOAD  = 2'd2
    } fetch_state_e;

    // Word-align an address by clearing the byte-offset bits.
    function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
        return {addr[WORD_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/dlx_fetch_watchdog.sv
// Fetch timeout counter.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_clear        : restart the count (fetch entry)
//   i_enable       : one more FETCH cycle elapsed without mem_ack
//   o_expired_c    : this enabled cycle is the TIMEOUT-th one without mem_ack
module dlx_fetch_watchdog #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired_c
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_cnt;

    // Counts waited cycles; r_cnt == LAST means TIMEOUT-1 cycles already elapsed.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && (r_cnt != LAST)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_expired_c = i_enable && (r_cnt == LAST);

endmodule

// File: rtl/dlx_ifetch_seq.sv
// DLX instruction-fetch sequencer: owns the PC, issues one word read per control
// request, captures the returned word and pulses the IR load strobe for one cycle.
// Optional feature macro: IFETCH_TIMEOUT_EN (abort a fetch after TIMEOUT unacked cycles).
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   fetch_req           : request next instruction (IDLE only)
//   pc_load, pc_in      : load word-aligned PC (any state)
//   mem_ack, mem_din    : memory read data valid / data
//   mem_addr, mem_rd    : registered fetch address / read request
//   ir_data, ir_en      : instruction word / one-cycle IR load strobe
//   fetch_done          : copy of ir_en for the control FSM
//   busy                : state != IDLE
//   pc_out              : current PC
//   fetch_err           : sticky timeout flag (0 without IFETCH_TIMEOUT_EN)
module dlx_ifetch_seq
    import dlx_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned       TIMEOUT  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic              pc_load,
    input  logic [WORD_W-1:0] pc_in,
    input  logic              mem_ack,
    input  logic [WORD_W-1:0] mem_din,
    output logic [WORD_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic [WORD_W-1:0] ir_data,
    output logic              ir_en,
    output logic              fetch_done,
    output logic              busy,
    output logic [WORD_W-1:0] pc_out,
    output logic              fetch_err
);

    fetch_state_e      r_state;
    logic [WORD_W-1:0] r_pc;
    logic [WORD_W-1:0] r_mem_addr;
    logic [WORD_W-1:0] r_ir_data;
    logic              r_mem_rd;
    logic              r_ir_en;
    logic              r_fetch_done;
    logic              r_busy;
    logic              r_fetch_err;
    logic              w_wd_expired;

    // Byte-offset bits of pc_in are discarded by word alignment.
    logic w_unused_pc_lsb;
    assign w_unused_pc_lsb = ^pc_in[1:0];

`ifdef IFETCH_TIMEOUT_EN
    logic w_wd_clear;
    logic w_wd_enable;

    assign w_wd_clear  = (r_state == ST_IDLE) && fetch_req;
    assign w_wd_enable = (r_state == ST_FETCH) && !mem_ack;

    dlx_fetch_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_clear     (w_wd_clear),
        .i_enable    (w_wd_enable),
        .o_expired_c (w_wd_expired)
    );
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^32'(TIMEOUT);
    assign w_wd_expired     = 1'b0;
`endif

    // Fetch FSM with PC, address and instruction registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_pc         <= RESET_PC;
            r_mem_addr   <= '0;
            r_ir_data    <= '0;
            r_mem_rd     <= 1'b0;
            r_ir_en      <= 1'b0;
            r_fetch_done <= 1'b0;
            r_busy       <= 1'b0;
            r_fetch_err  <= 1'b0;
        end else begin
            r_ir_en      <= 1'b0;
            r_fetch_done <= 1'b0;

            // A branch/jump load overrides the post-fetch increment.
            if (pc_load) begin
                r_pc <= word_align(pc_in);
            end else if (r_state == ST_LOAD) begin
                r_pc <= r_pc + PC_INC;
            end

            case (r_state)
                ST_IDLE: begin
                    if (fetch_req) begin
                        r_mem_addr  <= r_pc;
                        r_mem_rd    <= 1'b1;
                        r_busy      <= 1'b1;
                        r_fetch_err <= 1'b0;
                        r_state     <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    // A late ack in the expiry cycle still completes the fetch.
                    if (mem_ack) begin
                        r_ir_data    <= mem_din;
                        r_mem_rd     <= 1'b0;
                        r_ir_en      <= 1'b1;
                        r_fetch_done <= 1'b1;
                        r_state      <= ST_LOAD;
                    end else if (w_wd_expired) begin
                        r_mem_rd    <= 1'b0;
                        r_busy      <= 1'b0;
                        r_fetch_err <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_mem_rd <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_addr   = r_mem_addr;
    assign mem_rd     = r_mem_rd;
    assign ir_data    = r_ir_data;
    assign ir_en      = r_ir_en;
    assign fetch_done = r_fetch_done;
    assign busy       = r_busy;
    assign pc_out     = r_pc;
    assign fetch_err  = r_fetch_err;

endmodule

// File: tb/tb_dlx_ifetch_seq.sv
// Self-checking bench for dlx_ifetch_seq: cycle-level reference model plus directed
// scenarios with hand-computed expectations.
module tb_dlx_ifetch_seq;

    localparam int unsigned TB_TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_req = 1'b0;
    logic        pc_load = 1'b0;
    logic [31:0] pc_in = '0;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_din = '0;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic [31:0] ir_data;
    logic        ir_en;
    logic        fetch_done;
    logic        busy;
    logic [31:0] pc_out;
    logic        fetch_err;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    dlx_ifetch_seq #(
        .RESET_PC (32'h0000_0000),
        .TIMEOUT  (TB_TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .fetch_req  (fetch_req),
        .pc_load    (pc_load),
        .pc_in      (pc_in),
        .mem_ack    (mem_ack),
        .mem_din    (mem_din),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .ir_data    (ir_data),
        .ir_en      (ir_en),
        .fetch_done (fetch_done),
        .busy       (busy),
        .pc_out     (pc_out),
        .fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: a fetch is "in flight" from acceptance until ack (or timeout);
    // the strobe cycle follows the ack; PC moves by 4 per completed fetch unless loaded.
    bit          m_inflight = 0;
    bit          m_strobe   = 0;
    bit          m_err      = 0;
    int          m_waited   = 0;
    logic [31:0] m_pc = '0, m_addr = '0, m_data = '0;

    always @(posedge clk) begin
        logic [31:0] nxt_pc;
        if (reset) begin
            m_inflight = 0; m_strobe = 0; m_err = 0; m_waited = 0;
            m_pc = 32'h0; m_addr = 32'h0; m_data = 32'h0;
        end else begin
            nxt_pc = m_strobe ? m_pc + 32'd4 : m_pc;
            if (pc_load) nxt_pc = pc_in & 32'hFFFF_FFFC;
            if (m_strobe) begin
                m_strobe = 0;
            end else if (m_inflight) begin
                if (mem_ack) begin
                    m_data = mem_din;
                    m_inflight = 0;
                    m_strobe = 1;
                end else begin
                    m_waited++;
`ifdef IFETCH_TIMEOUT_EN
                    if (m_waited == TB_TIMEOUT) begin
                        m_inflight = 0;
                        m_err = 1;
                    end
`endif
                end
            end else if (fetch_req) begin
                m_inflight = 1;
                m_addr = m_pc;
                m_waited = 0;
                m_err = 0;
            end
            m_pc = nxt_pc;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("mem_rd",     32'(mem_rd),     32'(m_inflight));
            chk("busy",       32'(busy),       32'(m_inflight | m_strobe));
            chk("ir_en",      32'(ir_en),      32'(m_strobe));
            chk("fetch_done", 32'(fetch_done), 32'(m_strobe));
            chk("mem_addr",   mem_addr,        m_addr);
            chk("ir_data",    ir_data,         m_data);
            chk("pc_out",     pc_out,          m_pc);
            chk("fetch_err",  32'(fetch_err),  32'(m_err));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One fetch: request, `waits` unacked FETCH cycles, ack, then return to IDLE.
    // Optional pc_load pulse driven in loop iteration pl_at (LOAD is iteration waits+1).
    task automatic do_fetch(input logic [31:0] d, input int waits, input int pl_at,
                            input logic [31:0] pl_val,
                            output int n_rd, output int n_en, output int n_busy);
        n_rd = 0; n_en = 0; n_busy = 0;
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        for (int i = 0; i < waits + 3; i++) begin
            if (mem_rd) n_rd++;
            if (ir_en)  n_en++;
            if (busy)   n_busy++;
            mem_ack = (i == waits);
            mem_din = d;
            pc_load = (i == pl_at);
            pc_in   = pl_val;
            tick();
        end
        mem_ack = 1'b0;
        pc_load = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int n_rd, n_en, n_busy, cnt;

        reset = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();
        chk("rst_pc_out",  pc_out, 32'h0);
        chk("rst_ir_data", ir_data, 32'h0);
        chk("rst_busy",    32'(busy), 32'h0);
        reset = 1'b0;
        tick();

        // Zero-wait fetch.
        do_fetch(32'h2022_0005, 0, -1, 32'h0, n_rd, n_en, n_busy);
        chk("t1_n_rd",    32'(n_rd), 32'd1);
        chk("t1_n_en",    32'(n_en), 32'd1);
        chk("t1_ir_data", ir_data, 32'h2022_0005);
        chk("t1_mem_addr", mem_addr, 32'h0);
        chk("t1_pc_out",  pc_out, 32'h4);

        // Three wait cycles.
        do_fetch(32'hA5A5_0001, 3, -1, 32'h0, n_rd, n_en, n_busy);
        chk("t2_n_rd",   32'(n_rd), 32'd4);
        chk("t2_n_en",   32'(n_en), 32'd1);
        chk("t2_n_busy", 32'(n_busy), 32'd5);
        chk("t2_pc_out", pc_out, 32'h8);

        // pc_load during LOAD beats the increment.
        do_fetch(32'h1111_2222, 0, 1, 32'h0000_0103, n_rd, n_en, n_busy);
        chk("t3_pc_out", pc_out, 32'h0000_0100);
        do_fetch(32'h3333_4444, 1, -1, 32'h0, n_rd, n_en, n_busy);
        chk("t3_mem_addr", mem_addr, 32'h0000_0100);
        chk("t3_pc_next",  pc_out, 32'h0000_0104);

        // Load top-of-memory PC in IDLE, then wrap on completion.
        pc_load = 1'b1;
        pc_in   = 32'hFFFF_FFFF;
        tick();
        pc_load = 1'b0;
        chk("t4_pc_top", pc_out, 32'hFFFF_FFFC);
        do_fetch(32'h5555_6666, 0, -1, 32'h0, n_rd, n_en, n_busy);
        chk("t4_mem_addr", mem_addr, 32'hFFFF_FFFC);
        chk("t4_pc_wrap",  pc_out, 32'h0);

        // Held fetch_req with always-ready memory: one fetch per 3 cycles.
        fetch_req = 1'b1;
        mem_ack   = 1'b1;
        mem_din   = 32'h7777_8888;
        cnt = 0;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (ir_en) cnt++;
        end
        fetch_req = 1'b0;
        mem_ack   = 1'b0;
        tick();
        chk("t5_n_en",   32'(cnt), 32'd3);
        chk("t5_pc_out", pc_out, 32'd12);

        // Reset during FETCH, ack arrives afterwards.
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        tick();
        reset   = 1'b1;
        mem_ack = 1'b1;
        mem_din = 32'hDEAD_BEEF;
        tick();
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            if (ir_en) cnt++;
            tick();
        end
        mem_ack = 1'b0;
        chk("t6_n_en",    32'(cnt), 32'd0);
        chk("t6_ir_data", ir_data, 32'h0);
        chk("t6_pc_out",  pc_out, 32'h0);
        chk("t6_mem_rd",  32'(mem_rd), 32'h0);

        // Long unacknowledged fetch.
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        repeat (15) tick();
        chk("t7_rd_15", 32'(mem_rd), 32'h1);
`ifdef IFETCH_TIMEOUT_EN
        tick();
        chk("t7_rd_to",   32'(mem_rd), 32'h0);
        chk("t7_err",     32'(fetch_err), 32'h1);
        chk("t7_busy",    32'(busy), 32'h0);
        chk("t7_pc_out",  pc_out, 32'h0);
        repeat (2) tick();
        chk("t7_err_sticky", 32'(fetch_err), 32'h1);
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        chk("t7_err_clr", 32'(fetch_err), 32'h0);
`else
        repeat (10) tick();
        chk("t7_rd_wait", 32'(mem_rd), 32'h1);
        chk("t7_err_tie", 32'(fetch_err), 32'h0);
`endif
        mem_ack = 1'b1;
        mem_din = 32'h0BAD_F00D;
        tick();
        mem_ack = 1'b0;
        chk("t7_ir_en", 32'(ir_en), 32'h1);
        tick();
        chk("t7_ir_data", ir_data, 32'h0BAD_F00D);
        chk("t7_pc_done", pc_out, 32'h4);
        repeat (2) tick();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
